shuffle_sequencer: RTL
======================

Name: shuffle_sequencer

Overview:
Owns a 16-bit Fibonacci LFSR and uses it to produce a random permutation of NUM_ITEMS symbols (0..NUM_ITEMS-1) for a round of the memory game. On start it optionally reseeds the LFSR and draws candidates with rejection of duplicates until every slot is filled. It then holds the sequence for random-access reads by the game FSM and display logic. It sits between the top-level game controller and the LED/button handling.

Parameters:
NUM_ITEMS, 4, number of distinct symbols and sequence length (2..16)
IDX_W, 2, symbol/slot index width, equal to clog2(NUM_ITEMS)
SEED_DEFAULT, 16'hDEAD, LFSR reset value and substitute for a zero seed
MAX_DRAWS, 64, draw budget before deterministic fallback fill

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new shuffle; sampled only in IDLE
seed_load  in  1  qualifies start: load seed into LFSR before drawing
seed  in  16  seed value, used when start&seed_load
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the sequence is complete
seq_valid  out  1  sequence readable; set with done, cleared by next accepted start
rd_idx  in  IDX_W  slot to read
rd_data  out  IDX_W  symbol in slot rd_idx, combinational

Behaviour:
- Reset (asynchronous, any state): state=IDLE, LFSR=SEED_DEFAULT, all slots=0, used mask=0, count=0, draws=0, busy=0, done=0, seq_valid=0.
- LFSR step: new_bit = r[0]^r[2]^r[3]^r[5]; r <= {new_bit, r[15:1]}. It steps only in FILL, so results are deterministic from the seed.
- IDLE: start=1 accepts a shuffle. LFSR <= (seed_load ? (seed==0 ? SEED_DEFAULT : seed) : unchanged). Clear used, count, draws and seq_valid. Go to FILL. start=0 holds the state.
- FILL, one draw per cycle:
  - The candidate is the current r[IDX_W-1:0]. The LFSR steps and draws increments.
  - If candidate < NUM_ITEMS and it is not in used: slot[count] <= candidate, set used bit, count++. Otherwise reject with no write.
  - If count==NUM_ITEMS-1 on entry to the cycle, no draw occurs. slot[count] <= the single unused symbol, LFSR holds, go to DONE.
  - If draws reaches MAX_DRAWS with count < NUM_ITEMS-1, go to FALLBACK.
- FALLBACK: each cycle, slot[count] <= lowest unused symbol, set used bit, count++. When count reaches NUM_ITEMS-1, return to FILL so the final-slot rule completes it.
- DONE: lasts one cycle. done=1, seq_valid <= 1, then go to IDLE.
- Timing: with no rejections, done is high exactly NUM_ITEMS+1 cycles after the start-sampling edge. Each rejection adds one cycle.
- start while busy is ignored, not queued. seed and seed_load are ignored outside start acceptance.
- rd_data reflects slot contents at all times. Reads are only meaningful while seq_valid=1.
- A second start with seed_load=0 continues from the current LFSR state, so it gives a new permutation.

Decomposition:
- Shared package: state encoding (IDLE, FILL, FALLBACK, DONE), LFSR tap positions, and SEED_DEFAULT.
- Sub-module lfsr16 (inputs clk, rst_n, load, load_val, step; output state[15:0]) implements the polynomial above. It is instantiated once.
- The permutation bookkeeping (slots, used mask, count, draws) stays in shuffle_sequencer.

Test Plan:
- Seed DEAD: start with seed_load=1, seed=16'hDEAD, defaults. Required slots=1,2,3,0 and done on the 5th cycle after start. seq_valid=1 afterwards.
- Zero seed: start with seed_load=1, seed=0. Required output is identical to the DEAD case (1,2,3,0).
- Rejection: start with seed_load=1, seed=16'h0005. The 3rd draw (candidate 1) is rejected. Required slots=1,2,0,3 and done on the 6th cycle after start.
- Fallback: MAX_DRAWS=2, seed=16'hDEAD. Required slots=1,2,0,3 via the fallback fill. done follows with no further LFSR steps.
- Ignored start: pulse start during FILL of the DEAD case. Required result unchanged (1,2,3,0) and only one done pulse. Then start with seed_load=0: seq_valid drops and a new permutation completes.
- Mid-operation reset: assert rst_n=0 during FILL. All outputs must return to reset values immediately. A following DEAD-seed start must reproduce 1,2,3,0.

Source files
------------

// File: rtl/shuffle_sequencer_pkg.sv
// Shared definitions for the shuffle sequencer: FSM states, LFSR taps, default seed.
package shuffle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FALLBACK,
    ST_DONE
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hDEAD;

  // Feedback taps of the 16-bit Fibonacci LFSR (shift toward bit 0).
  localparam int unsigned LFSR_TAP0 = 0;
  localparam int unsigned LFSR_TAP1 = 2;
  localparam int unsigned LFSR_TAP2 = 3;
  localparam int unsigned LFSR_TAP3 = 5;

endpackage

// File: rtl/shuffle_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
module lfsr16
  import shuffle_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  logic feedback;

  always_comb begin
    feedback = state[LFSR_TAP0] ^ state[LFSR_TAP1] ^ state[LFSR_TAP2] ^ state[LFSR_TAP3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/shuffle_sequencer.sv
// Builds a random permutation of 0..NUM_ITEMS-1 by LFSR draws with duplicate
// rejection, falling back to a deterministic fill once the draw budget runs out.
module shuffle_sequencer
  import shuffle_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ITEMS    = 4,
  parameter int unsigned IDX_W        = 2,
  parameter logic [15:0] SEED_DEFAULT = DEFAULT_SEED,
  parameter int unsigned MAX_DRAWS    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             seq_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W-1:0] rd_data
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned DRAW_W = $clog2(MAX_DRAWS + 1);
  localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(NUM_ITEMS - 1);
  localparam logic [DRAW_W-1:0] DRAW_LIMIT = DRAW_W'(MAX_DRAWS);

  state_t state_q, state_nxt;

  logic [IDX_W-1:0]     slots [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] used;
  logic [CNT_W-1:0]     count;
  logic [DRAW_W-1:0]    draws;

  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_load_val;
  logic             lfsr_load;
  logic             lfsr_step;
  logic [IDX_W-1:0] cand;
  logic             cand_ok;
  logic [IDX_W-1:0] free_sym;
  logic             free_found;
  logic [CNT_W-1:0] count_after;

  logic             clear;
  logic             wr_en;
  logic [IDX_W-1:0] wr_sym;
  logic             draw_inc;
  logic             set_valid;

  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_q[15:IDX_W];

  lfsr16 #(
    .RESET_VAL(SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .load_val(lfsr_load_val),
    .step    (lfsr_step),
    .state   (lfsr_q)
  );

  assign lfsr_load_val = (seed == 16'h0000) ? SEED_DEFAULT : seed;
  assign cand          = lfsr_q[IDX_W-1:0];
  assign cand_ok       = ({1'b0, cand} < CNT_W'(NUM_ITEMS)) && !used[cand];
  assign count_after   = count + CNT_W'(cand_ok);
  assign rd_data       = slots[rd_idx];

  // Lowest unused symbol; in the final slot this is the only one left.
  always_comb begin
    free_sym   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (!used[i] && !free_found) begin
        free_sym   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    clear     = 1'b0;
    wr_en     = 1'b0;
    wr_sym    = '0;
    draw_inc  = 1'b0;
    set_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          lfsr_load = seed_load;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (count == LAST_SLOT) begin
          wr_en     = 1'b1;
          wr_sym    = free_sym;
          set_valid = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          lfsr_step = 1'b1;
          draw_inc  = 1'b1;
          wr_en     = cand_ok;
          wr_sym    = cand;
          // Budget check uses the post-draw count so a draw that fills the
          // penultimate slot still lets the final-slot rule finish normally.
          if ((draws + DRAW_W'(1)) == DRAW_LIMIT && count_after < LAST_SLOT) begin
            state_nxt = ST_FALLBACK;
          end
        end
      end
      ST_FALLBACK: begin
        wr_en  = 1'b1;
        wr_sym = free_sym;
        if ((count + CNT_W'(1)) == LAST_SLOT) begin
          state_nxt = ST_FILL;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        slots[i] <= '0;
      end
      used      <= '0;
      count     <= '0;
      draws     <= '0;
      seq_valid <= 1'b0;
    end else if (clear) begin
      used      <= '0;
      count     <= '0;
      draws     <= '0;
      seq_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        slots[count[IDX_W-1:0]] <= wr_sym;
        used[wr_sym]            <= 1'b1;
        count                   <= count + CNT_W'(1);
      end
      if (draw_inc) begin
        draws <= draws + DRAW_W'(1);
      end
      if (set_valid) begin
        seq_valid <= 1'b1;
      end
    end
  end

endmodule
